// File: rtl/nes_gamepad_device.sv
// Device-side NES pad: answers a host's latch/clock pins with an 8-bit active-low
// serial button stream, behaving like a CD4021 shift register behind pin filters.
module nes_gamepad_device #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter bit          FILL_BIT      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_button_state,
  input  logic       i_data_latch,
  input  logic       i_data_clock,
  output logic       o_serial_data,
  output logic [7:0] o_sampled,
  output logic       o_latch_pulse,
  output logic       o_frame_done,
  output logic [3:0] o_read_count,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] FC_LAST = 4'(FILTER_CYCLES - 1);

  // Pin index 0 = latch, 1 = clock.
  logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
  logic [1:0][3:0] fcnt_q, fcnt_d;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] sampled_q, sampled_d;
  logic [3:0] count_q, count_d;
  logic       pin_q, pin_d;
  logic       latch_pulse_q, latch_pulse_d;
  logic       frame_done_q, frame_done_d;

  logic latch_rise, latch_fall, clk_rise;

  // The filtered level only moves after FILTER_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FC_LAST) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = 4'd0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end else begin
        fcnt_d[i] = 4'd0;
      end
    end
  end

  assign latch_rise = filt_q[0] & ~filt_prev_q[0];
  assign latch_fall = ~filt_q[0] & filt_prev_q[0];
  assign clk_rise   = filt_q[1] & ~filt_prev_q[1];

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    sampled_d     = sampled_q;
    count_d       = count_q;
    latch_pulse_d = 1'b0;
    frame_done_d  = 1'b0;
    pin_d         = 1'b1;

    // Latch events win; a clock edge in the same cycle is dropped.
    if (latch_rise) begin
      state_d = LOAD;
      count_d = 4'd0;
    end else if (latch_fall) begin
      if (state_q == LOAD) begin
        state_d       = SHIFT;
        sampled_d     = shreg_q;
        latch_pulse_d = 1'b1;
        count_d       = 4'd0;
      end
    end else if (clk_rise) begin
      case (state_q)
        SHIFT: begin
          shreg_d = {FILL_BIT, shreg_q[7:1]};
          count_d = count_q + 4'd1;
          if (count_q == 4'd7) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end
        end
        DONE, IDLE: begin
          if (count_q != 4'd15) count_d = count_q + 4'd1;
        end
        default: ;
      endcase
    end

    if (state_d == LOAD) shreg_d = i_button_state;

    // In LOAD the pin follows the previously reloaded value, giving a two-cycle button-to-pin path.
    case (state_d)
      LOAD:    pin_d = ~shreg_q[0];
      SHIFT:   pin_d = ~shreg_d[0];
      DONE:    pin_d = ~FILL_BIT;
      default: pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      filt_q        <= '0;
      filt_prev_q   <= '0;
      fcnt_q        <= '0;
      state_q       <= IDLE;
      shreg_q       <= '0;
      sampled_q     <= '0;
      count_q       <= '0;
      pin_q         <= 1'b1;
      latch_pulse_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      sync1_q       <= {i_data_clock, i_data_latch};
      sync2_q       <= sync1_q;
      filt_q        <= filt_d;
      filt_prev_q   <= filt_q;
      fcnt_q        <= fcnt_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      sampled_q     <= sampled_d;
      count_q       <= count_d;
      pin_q         <= pin_d;
      latch_pulse_q <= latch_pulse_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign o_serial_data = pin_q;
  assign o_sampled     = sampled_q;
  assign o_latch_pulse = latch_pulse_q;
  assign o_frame_done  = frame_done_q;
  assign o_read_count  = count_q;
  assign o_dbg_state   = state_q;

endmodule

// File: doc/nes_gamepad_device.md
# nes_gamepad_device

Device-side NES controller port: emulates a CD4021-based pad on the console end of the same latch/clock/serial-data link our host-side gamepad reader drives. It accepts a parallel button vector from the design (USB/BT bridge or test logic). It answers an external or internal NES host's latch and clock pins with the 8-bit serial stream, in standard order and with standard active-low pin polarity. Pin inputs are asynchronous and are synchronised, glitch-filtered and edge-detected internally.

## Interface
- `FILTER_CYCLES`, default 4: consecutive stable cycles (after the synchroniser) a pin level must hold before it is accepted; legal range 1..15.
- `FILL_BIT`, default 1: logical bit returned for reads beyond the 8th. 1 means "pressed", so the pin is driven 0, matching official pads.

Ports:
- `i_clk` (in, 1): system clock, 27 MHz nominal.
- `i_rst_n` (in, 1): asynchronous, active-low reset.
- `i_button_state` (in, 8): 1 = pressed. bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
- `i_data_latch` (in, 1): host latch pin, asynchronous, active high.
- `i_data_clock` (in, 1): host clock pin, asynchronous. Shift happens on the rising edge.
- `o_serial_data` (out, 1): data pin, active low (0 = pressed), registered.
- `o_sampled` (out, 8): button vector captured at the falling edge of latch.
- `o_latch_pulse` (out, 1): 1-cycle pulse on accepted latch fall.
- `o_frame_done` (out, 1): 1-cycle pulse when the 8th bit has been shifted out.
- `o_read_count` (out, 4): rising clock edges accepted since the last latch fall, saturating at 15.

## Operation
- Input conditioning, per pin:
  - 2-flop synchroniser, then a filter counter.
  - The filtered level flips only after the synchronised level has differed from it for `FILTER_CYCLES` consecutive cycles. Any agreeing sample clears the counter.
  - Rise and fall events are taken from the filtered level only.
- FSM states:
  - IDLE: after reset. Shift register = 0, pin = 1.
  - LOAD: latch high. The shift register reloads from `i_button_state` every cycle. Clock edges are ignored (4021 parallel mode). The pin shows the live bit0.
  - SHIFT: latch low, fewer than 8 shifts done.
  - DONE: 8 shifts done.
- Transitions:
  - Latch rise from any state goes to LOAD. An in-progress SHIFT is aborted and the count is cleared.
  - Latch fall in LOAD goes to SHIFT. On that fall: `o_sampled` <= shift register, `o_latch_pulse`=1, `o_read_count`=0.
  - Clock rise in SHIFT: shift right, MSB filled with `FILL_BIT`, count+1. When the count reaches 8, go to DONE and pulse `o_frame_done`.
  - Clock rise in DONE or IDLE: count+1, saturating at 15. The pin is held at ~`FILL_BIT`. In IDLE the pin stays 1.
- Pin output is ~shreg[0] in LOAD and SHIFT.
- Simultaneous filtered latch and clock events in the same cycle: latch is processed and the clock event is discarded.
- `i_button_state` changes outside LOAD have no effect on the current frame.

## Timing
- Reset values (asynchronous assertion, synchronous release):
  - `o_serial_data`=1, `o_sampled`=0, `o_latch_pulse`=0, `o_frame_done`=0, `o_read_count`=0.
  - State IDLE; synchronisers and filtered levels 0; filter counters 0.
- Pin-to-effect latency: a pin change first sampled at edge k produces its effect (state, `o_serial_data`, pulses) at edge k+2+`FILTER_CYCLES`, exactly.
- In LOAD, `i_button_state` reaches `o_serial_data` with 2 cycles of latency (reload, then output register).
- Glitch rule: pulses shorter than `FILTER_CYCLES` synchronised cycles are never seen. Minimum accepted host high/low time is `FILTER_CYCLES`+1 cycles.
- Reset mid-frame: immediate return to IDLE. The next frame requires a fresh latch rise.
- The bench must not assume any pin-to-pin combinational path; all outputs are registered.

## Test plan
- Reset, then 100 idle cycles with pins low: `o_serial_data`=1, all pulses 0, `o_read_count`=0.
- Buttons 8'b1000_0101; latch high for 12 µs, then 8 clock pulses of 6 µs high / 6 µs low:
  - pin sequence before each rise: 0,1,0,1,1,1,1,0.
  - `o_sampled`=8'h85, one `o_latch_pulse`, one `o_frame_done` after the 8th rise.
- Continue with 4 extra clocks: pin stays 0 (FILL_BIT=1); `o_read_count` ends at 12. Repeat with FILL_BIT=0: pin stays 1.
- Glitches of 3 cycles on latch and on clock, with FILTER_CYCLES=4: no state change, no pulses, `o_read_count` unchanged.
- Latch rise after 3 clocks with buttons changed to 8'h01: frame aborts, count returns to 0, the new frame streams bit0=pressed, and there is exactly one `o_frame_done`, from the new frame.
- `i_rst_n` asserted mid-SHIFT (after 5 clocks): all outputs return to reset values within the same cycle. Clocks before the next latch leave the pin at 1.
